// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_pkg: shared sizes, types and helpers for the sprite ROM arbiter.
//   N_SPR   number of requesting sprites (index 0 = highest priority)
//   AW      sprite ROM address width (32x32 sprite)
//   CW      colour width (RGB444)
//   TRANSP  colour value treated as transparent
//   owner_t winning-sprite index type
//   arb_stage_t  per-pixel arbitration record carried down the ROM pipeline
package sprite_pkg;

  localparam int N_SPR = 4;
  localparam int AW    = 10;
  localparam int CW    = 12;
  localparam logic [CW-1:0] TRANSP = 12'h000;

  // N_SPR must be >= 2 so the owner index has at least one bit.
  localparam int OW = $clog2(N_SPR);

  typedef logic [OW-1:0] owner_t;

  typedef struct packed {
    logic             any_hit;
    owner_t           win;
    logic [N_SPR-1:0] hits;
    logic             fs;
  } arb_stage_t;

  function automatic int unsigned popcount(input logic [N_SPR-1:0] v);
    popcount = 0;
    for (int i = 0; i < N_SPR; i++) begin
      if (v[i]) popcount++;
    end
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: pixel-rate bus between the sprite drivers / ROM and
// the arbiter.
//   frame_start  1-cycle pulse on the first pixel of a frame
//   hit          sprite i box covers the current pixel
//   req_addr     sprite i ROM address, slice [i*AW +: AW]
//   rom_addr     shared ROM address
//   rom_data     ROM data, valid ROM_LAT cycles after rom_addr
//   pix_valid    pix_color belongs to a sprite and is opaque
//   pix_color    composited sprite colour (TRANSP when !pix_valid)
//   pix_owner    winning sprite index (0 when no hit)
//   collide_mask sprites that collided during the previous frame
//   collide_stb  1-cycle pulse when collide_mask updates
// slave = arbiter side, master = sprite drivers / ROM / display side.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
();

  logic                frame_start;
  logic [N_SPR-1:0]    hit;
  logic [N_SPR*AW-1:0] req_addr;
  logic [AW-1:0]       rom_addr;
  logic [CW-1:0]       rom_data;
  logic                pix_valid;
  logic [CW-1:0]       pix_color;
  owner_t              pix_owner;
  logic [N_SPR-1:0]    collide_mask;
  logic                collide_stb;

  modport slave (
    input  frame_start, hit, req_addr, rom_data,
    output rom_addr, pix_valid, pix_color, pix_owner, collide_mask, collide_stb
  );

  modport master (
    output frame_start, hit, req_addr, rom_data,
    input  rom_addr, pix_valid, pix_color, pix_owner, collide_mask, collide_stb
  );

endinterface

// File: rtl/spr_prio_enc.sv
// spr_prio_enc: combinational fixed-priority encoder, lowest index wins.
//   hit      in   request vector
//   any_hit  out  at least one request
//   win      out  lowest set index (0 when no request)
module spr_prio_enc
  import sprite_pkg::*;
(
  input  logic [N_SPR-1:0] hit,
  output logic             any_hit,
  output owner_t           win
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_hit = |hit;
    win     = '0;
    // Scan from the top down so the lowest set index is written last.
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) win = owner_t'(i);
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one sprite-pixel ROM port between N_SPR sprites.
// Each pixel the lowest-index sprite covering the pixel drives the ROM address;
// its arbitration record travels alongside the ROM read so the returned colour,
// owner and per-frame collision mask line up with rom_data.
//   pixel_clk    in   pixel clock, all logic on posedge
//   rst_n        in   async active-low reset
//   bus          slave modport of sprite_rom_arbiter_if (handshake/pixel bus)
//   starve_cnt   out  per-sprite 16-bit hidden-pixel counts of the previous
//                     frame, slice [i*16 +: 16]; present only when
//                     SPRITE_ARB_STARVE_CNT_EN is defined
// Parameter ROM_LAT (>=1): ROM read latency in pixel_clk cycles.
// Latency from hit to pix_* is ROM_LAT+2 cycles.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  sprite_rom_arbiter_if.slave     bus
`ifdef SPRITE_ARB_STARVE_CNT_EN
  ,
  output logic [N_SPR*16-1:0]     starve_cnt
`endif
);

  logic             any_hit;
  owner_t           win;
  logic [AW-1:0]    sel_addr;
  arb_stage_t       stg [0:ROM_LAT];
  arb_stage_t       al;
  logic             opaque;
  logic [N_SPR-1:0] col_bits;
  logic [N_SPR-1:0] acc;

  spr_prio_enc u_enc (
    .hit     (bus.hit),
    .any_hit (any_hit),
    .win     (win)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_SPR; i++) begin
      if (any_hit && win == owner_t'(i)) sel_addr = bus.req_addr[i*AW +: AW];
    end
  end

  // stg[0] is captured with rom_addr; stg[ROM_LAT] is therefore aligned with
  // the rom_data that address produced.
  assign al       = stg[ROM_LAT];
  assign opaque   = (bus.rom_data != TRANSP);
  assign col_bits = (popcount(al.hits) >= 2 && opaque) ? al.hits : '0;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_addr <= '0;
      // NOTE: this is a short pipeline of flops, not a RAM, so it is reset to
      // flush stale hits; a real memory array would be left unreset.
      for (int i = 0; i <= ROM_LAT; i++) stg[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's
      // old value, which is what makes this a shift register.
      bus.rom_addr <= sel_addr;
      stg[0]       <= '{any_hit: any_hit, win: win, hits: bus.hit, fs: bus.frame_start};
      for (int i = 1; i <= ROM_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pix_valid    <= 1'b0;
      bus.pix_color    <= TRANSP;
      bus.pix_owner    <= '0;
      bus.collide_mask <= '0;
      bus.collide_stb  <= 1'b0;
      acc              <= '0;
    end else begin
      bus.pix_valid   <= al.any_hit && opaque;
      bus.pix_color   <= (al.any_hit && opaque) ? bus.rom_data : TRANSP;
      bus.pix_owner   <= al.win;
      bus.collide_stb <= al.fs;
      if (al.fs) begin
        // The frame_start pixel still belongs to the frame being closed.
        bus.collide_mask <= acc | col_bits;
        acc              <= '0;
      end else begin
        acc <= acc | col_bits;
      end
    end
  end

`ifdef SPRITE_ARB_STARVE_CNT_EN
  logic [15:0] cnt_q   [N_SPR];
  logic [15:0] cnt_nxt [N_SPR];

  // A sprite is starved on an aligned pixel it covers but did not win.
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (al.hits[i] && al.win != owner_t'(i) && cnt_q[i] != 16'hFFFF)
        cnt_nxt[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      for (int i = 0; i < N_SPR; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SPR; i++) begin
        if (al.fs) begin
          starve_cnt[i*16 +: 16] <= cnt_nxt[i];
          cnt_q[i]               <= '0;
        end else begin
          cnt_q[i] <= cnt_nxt[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter with a 1-cycle synchronous ROM model.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int ROM_LAT = 1;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sprite_rom_arbiter_if bus ();

`ifdef SPRITE_ARB_STARVE_CNT_EN
  logic [N_SPR*16-1:0] starve_cnt;
`endif

  sprite_rom_arbiter #(.ROM_LAT(ROM_LAT)) dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef SPRITE_ARB_STARVE_CNT_EN
    ,
    .starve_cnt(starve_cnt)
`endif
  );

  // Sprite ROM model: one-cycle registered read.
  logic [CW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.hit = '0; bus.req_addr = '0; bus.frame_start = 1'b0;
    #13;
    tests++; if (bus.rom_addr !== '0) begin fails++; $display("FAIL rst_rom_addr: got %h, expected 000", bus.rom_addr); end
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL rst_pix_valid: got %b, expected 0", bus.pix_valid); end
    tests++; if (bus.pix_color !== TRANSP) begin fails++; $display("FAIL rst_pix_color: got %h, expected %h", bus.pix_color, TRANSP); end
    tests++; if (bus.pix_owner !== '0) begin fails++; $display("FAIL rst_pix_owner: got %0d, expected 0", bus.pix_owner); end
    tests++; if (bus.collide_mask !== '0) begin fails++; $display("FAIL rst_collide_mask: got %b, expected 0000", bus.collide_mask); end
    tests++; if (bus.collide_stb !== 1'b0) begin fails++; $display("FAIL rst_collide_stb: got %b, expected 0", bus.collide_stb); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    bus.req_addr = {10'h2AA, 10'h155, 10'h0F0, 10'h001};
    bus.hit = 4'b0100;
    tick();
    tests++; if (bus.rom_addr !== 10'h155) begin fails++; $display("FAIL single_rom_addr: got %h, expected 155", bus.rom_addr); end
    bus.hit = 4'b0000;
    tick();
    tests++; if (bus.rom_addr !== 10'h000) begin fails++; $display("FAIL single_rom_addr_idle: got %h, expected 000", bus.rom_addr); end
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b, expected 0", bus.pix_valid); end
    tick();
    tests++; if (bus.pix_valid !== 1'b1) begin fails++; $display("FAIL single_pix_valid: got %b, expected 1", bus.pix_valid); end
    tests++; if (bus.pix_color !== 12'hFA5) begin fails++; $display("FAIL single_pix_color: got %h, expected FA5", bus.pix_color); end
    tests++; if (bus.pix_owner !== 2'd2) begin fails++; $display("FAIL single_pix_owner: got %0d, expected 2", bus.pix_owner); end
    tick();
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL single_pix_drop: got %b, expected 0", bus.pix_valid); end
  endtask

  task automatic test_priority();
    bus.req_addr = {10'h3FF, 10'h000, 10'h011, 10'h000};
    bus.hit = 4'b1010;
    tick();
    tests++; if (bus.rom_addr !== 10'h011) begin fails++; $display("FAIL prio_rom_addr: got %h, expected 011", bus.rom_addr); end
    bus.hit = 4'b0000;
    tick();
    tick();
    tests++; if (bus.pix_valid !== 1'b1) begin fails++; $display("FAIL prio_pix_valid: got %b, expected 1", bus.pix_valid); end
    tests++; if (bus.pix_color !== 12'hABC) begin fails++; $display("FAIL prio_pix_color: got %h, expected ABC", bus.pix_color); end
    tests++; if (bus.pix_owner !== 2'd1) begin fails++; $display("FAIL prio_pix_owner: got %0d, expected 1", bus.pix_owner); end
  endtask

  task automatic test_transparent();
    bus.req_addr = {10'h000, 10'h000, 10'h011, 10'h200};
    bus.hit = 4'b0011;
    tick();
    tests++; if (bus.rom_addr !== 10'h200) begin fails++; $display("FAIL transp_rom_addr: got %h, expected 200", bus.rom_addr); end
    bus.hit = 4'b0000;
    tick();
    tick();
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL transp_pix_valid: got %b, expected 0", bus.pix_valid); end
    tests++; if (bus.pix_color !== TRANSP) begin fails++; $display("FAIL transp_pix_color: got %h, expected 000", bus.pix_color); end
    tests++; if (bus.pix_owner !== 2'd0) begin fails++; $display("FAIL transp_pix_owner: got %0d, expected 0", bus.pix_owner); end
  endtask

  // Closes the frame holding the priority (opaque, 2 hits -> 1010) and the
  // transparent (2 hits, no collision) pixels.
  task automatic test_frame_flush();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    tests++; if (bus.collide_stb !== 1'b0) begin fails++; $display("FAIL flush_stb_early: got %b, expected 0", bus.collide_stb); end
    tick();
    tests++; if (bus.collide_stb !== 1'b1) begin fails++; $display("FAIL flush_stb: got %b, expected 1", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b1010) begin fails++; $display("FAIL flush_mask: got %b, expected 1010", bus.collide_mask); end
`ifdef SPRITE_ARB_STARVE_CNT_EN
    tests++; if (starve_cnt !== {16'd1, 16'd0, 16'd1, 16'd0}) begin fails++; $display("FAIL flush_starve_cnt: got %h, expected %h", starve_cnt, {16'd1, 16'd0, 16'd1, 16'd0}); end
`endif
    tick();
    tests++; if (bus.collide_stb !== 1'b0) begin fails++; $display("FAIL flush_stb_pulse: got %b, expected 0", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b1010) begin fails++; $display("FAIL flush_mask_hold: got %b, expected 1010", bus.collide_mask); end
  endtask

  task automatic test_collision_frame();
    bus.req_addr = {10'h000, 10'h000, 10'h011, 10'h0A0};
    bus.hit = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) begin
        tests++; if (bus.pix_valid !== 1'b1 || bus.pix_color !== 12'h777) begin fails++; $display("FAIL coll_pixel: got valid %b color %h, expected 1 777", bus.pix_valid, bus.pix_color); end
      end
    end
    bus.hit = 4'b0000;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    tick();
    tests++; if (bus.collide_stb !== 1'b1) begin fails++; $display("FAIL coll_stb: got %b, expected 1", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b0011) begin fails++; $display("FAIL coll_mask: got %b, expected 0011", bus.collide_mask); end
    tick();
    tests++; if (bus.collide_stb !== 1'b0) begin fails++; $display("FAIL coll_stb_pulse: got %b, expected 0", bus.collide_stb); end
    // Next frame: a single sprite only, so no overlap.
    bus.hit = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    bus.hit = 4'b0000;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    tick();
    tests++; if (bus.collide_stb !== 1'b1) begin fails++; $display("FAIL nocoll_stb: got %b, expected 1", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b0000) begin fails++; $display("FAIL nocoll_mask: got %b, expected 0000", bus.collide_mask); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.req_addr = {10'h000, 10'h000, 10'h011, 10'h0A0};
    bus.hit = 4'b0011;
    bus.frame_start = 1'b1;
    tick();
    bus.hit = 4'b0000;
    tick();
    bus.frame_start = 1'b0;
    tick();
    tests++; if (bus.collide_stb !== 1'b1) begin fails++; $display("FAIL b2b_stb1: got %b, expected 1", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b0011) begin fails++; $display("FAIL b2b_mask1: got %b, expected 0011", bus.collide_mask); end
    tick();
    tests++; if (bus.collide_stb !== 1'b1) begin fails++; $display("FAIL b2b_stb2: got %b, expected 1", bus.collide_stb); end
    tests++; if (bus.collide_mask !== 4'b0000) begin fails++; $display("FAIL b2b_mask2: got %b, expected 0000", bus.collide_mask); end
    tick();
    tests++; if (bus.collide_stb !== 1'b0) begin fails++; $display("FAIL b2b_stb_end: got %b, expected 0", bus.collide_stb); end
  endtask

  task automatic test_reset_midstream();
    bus.req_addr = {10'h000, 10'h155, 10'h000, 10'h000};
    bus.hit = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    tests++; if (bus.pix_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b, expected 1", bus.pix_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.rom_addr !== '0) begin fails++; $display("FAIL mid_rom_addr: got %h, expected 000", bus.rom_addr); end
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL mid_pix_valid: got %b, expected 0", bus.pix_valid); end
    tests++; if (bus.pix_color !== TRANSP) begin fails++; $display("FAIL mid_pix_color: got %h, expected 000", bus.pix_color); end
    tests++; if (bus.pix_owner !== '0) begin fails++; $display("FAIL mid_pix_owner: got %0d, expected 0", bus.pix_owner); end
    tests++; if (bus.collide_mask !== '0 || bus.collide_stb !== 1'b0) begin fails++; $display("FAIL mid_collide: got mask %b stb %b, expected 0000 0", bus.collide_mask, bus.collide_stb); end
`ifdef SPRITE_ARB_STARVE_CNT_EN
    tests++; if (starve_cnt !== '0) begin fails++; $display("FAIL mid_starve_cnt: got %h, expected 0", starve_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL mid_post0_valid: got %b, expected 0", bus.pix_valid); end
    tick();
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL mid_post1_valid: got %b, expected 0", bus.pix_valid); end
    tick();
    tests++; if (bus.pix_valid !== 1'b0) begin fails++; $display("FAIL mid_post2_valid: got %b, expected 0", bus.pix_valid); end
    tick();
    tests++; if (bus.pix_valid !== 1'b1 || bus.pix_color !== 12'hFA5) begin fails++; $display("FAIL mid_post3_pixel: got valid %b color %h, expected 1 FA5", bus.pix_valid, bus.pix_color); end
    bus.hit = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = TRANSP;
    rom_mem[10'h155] = 12'hFA5;
    rom_mem[10'h011] = 12'hABC;
    rom_mem[10'h3FF] = 12'h123;
    rom_mem[10'h0A0] = 12'h777;
    rom_mem[10'h200] = 12'h000;

    test_reset();
    test_single_hit();
    test_priority();
    test_transparent();
    test_frame_flush();
    test_collision_frame();
    test_back_to_back();
    test_reset_midstream();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
